// File: rtl/cnn_pkg.sv
// Shared geometry, FSM state encoding and window bit-layout helper for the
// 5x5 classifier window sequencer.
package cnn_pkg;

    localparam int IMG_W      = 28;
    localparam int K          = 5;
    localparam int PIX_W      = 8;
    localparam int OUT_W      = IMG_W - K + 1;
    localparam int PIXELS     = IMG_W * IMG_W;
    localparam int LAST_INDEX = OUT_W * OUT_W - 1;
    localparam int WIN_W      = K * K * PIX_W;
    localparam int ADDR_W     = 10;
    localparam int XY_W       = 5;
    localparam int CLS_W      = 4;

    typedef enum logic [2:0] {
        LOAD,
        CRST,
        STRT,
        ARM,
        SCAN,
        WAIT,
        RES
    } state_t;

    // MSB of window pixel (r,c); pixel (0,0) sits in the top byte.
    function automatic int win_msb(input int r, input int c);
        return WIN_W - 1 - (r * K + c) * PIX_W;
    endfunction

endpackage

// File: rtl/cnn_frame_buffer.sv
// One-image pixel store: single write port, combinational KxK window read
// at (x,y); window reads as zero when en is low.
module cnn_frame_buffer
    import cnn_pkg::*;
(
    input  logic                CLK,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [PIX_W-1:0]    wdata,
    input  logic                en,
    input  logic [XY_W-1:0]     x,
    input  logic [XY_W-1:0]     y,
    output logic [WIN_W-1:0]    win
);

    logic [PIX_W-1:0] mem [PIXELS];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        win = '0;
        if (en) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win[win_msb(r, c) -: PIX_W] =
                        mem[ADDR_W'((int'(y) + r) * IMG_W + int'(x) + c)];
                end
            end
        end
    end

endmodule

// File: rtl/cnn_window_sequencer.sv
// Frame controller: load 784 pixels, pulse core reset/start, scan 576 windows
// one per cycle, wait for done (bounded), hold the class until consumed.
module cnn_window_sequencer
    import cnn_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                pix_valid,
    input  logic [PIX_W-1:0]    pix_data,
    output logic                pix_ready,
    output logic                core_rst,
    output logic                core_start,
    output logic [XY_W-1:0]     core_x,
    output logic [XY_W-1:0]     core_y,
    output logic [WIN_W-1:0]    core_win,
    input  logic                core_done,
    input  logic [CLS_W-1:0]    core_out,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [CLS_W-1:0]    res_class,
    output logic                res_err
);

    localparam int T_W = $clog2(TIMEOUT + 1);

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  p_q;
    logic [XY_W-1:0]    x_q, y_q;
    logic [T_W-1:0]     t_q;
    logic               accept;
    logic               scan_last;

    assign accept    = pix_valid & pix_ready;
    assign scan_last = (x_q == XY_W'(OUT_W - 1)) && (y_q == XY_W'(OUT_W - 1));
    assign core_x    = x_q;
    assign core_y    = y_q;

    always_comb begin
        state_nx = state;
        case (state)
            LOAD: if (accept && p_q == ADDR_W'(PIXELS - 1)) state_nx = CRST;
            CRST: state_nx = STRT;
            STRT: state_nx = ARM;
            ARM:  state_nx = SCAN;
            SCAN: if (scan_last) state_nx = WAIT;
            WAIT: if (core_done || t_q == T_W'(TIMEOUT - 1)) state_nx = RES;
            RES:  if (res_ready) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    // Handshake/control outputs are flopped from the next state so they line
    // up exactly with the state they belong to.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            state      <= LOAD;
            p_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            t_q        <= '0;
            pix_ready  <= 1'b0;
            core_rst   <= 1'b1;
            core_start <= 1'b0;
            res_valid  <= 1'b0;
            res_class  <= '0;
            res_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            pix_ready  <= (state_nx == LOAD);
            core_rst   <= (state_nx == CRST);
            core_start <= (state_nx == STRT);
            res_valid  <= (state_nx == RES);

            if (accept) begin
                p_q <= (p_q == ADDR_W'(PIXELS - 1)) ? '0 : p_q + 1'b1;
            end

            if (state == SCAN) begin
                if (x_q == XY_W'(OUT_W - 1)) begin
                    x_q <= '0;
                    y_q <= (y_q == XY_W'(OUT_W - 1)) ? '0 : y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end

            if (state == WAIT) begin
                t_q <= t_q + 1'b1;
                if (state_nx == RES) begin
                    t_q       <= '0;
                    res_class <= core_done ? core_out : '0;
                    res_err   <= ~core_done;
                end
            end
        end
    end

    cnn_frame_buffer u_fb (
        .CLK   (CLK),
        .we    (accept),
        .waddr (p_q),
        .wdata (pix_data),
        .en    (state == SCAN),
        .x     (x_q),
        .y     (y_q),
        .win   (core_win)
    );

endmodule

// File: tb/tb_cnn_window_sequencer.sv
// Frame-level bench for cnn_window_sequencer with a behavioural core model
// and a result scoreboard.
module tb_cnn_window_sequencer;
    import cnn_pkg::*;

    logic               CLK = 1'b0;
    logic               nRST = 1'b1;
    logic               pix_valid = 1'b0;
    logic [PIX_W-1:0]   pix_data = '0;
    logic               pix_ready;
    logic               core_rst;
    logic               core_start;
    logic [XY_W-1:0]    core_x;
    logic [XY_W-1:0]    core_y;
    logic [WIN_W-1:0]   core_win;
    logic               core_done = 1'b0;
    logic [CLS_W-1:0]   core_out = '0;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic [CLS_W-1:0]   res_class;
    logic               res_err;

    always #5 CLK = ~CLK;

    cnn_window_sequencer #(.TIMEOUT(8)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .core_rst   (core_rst),
        .core_start (core_start),
        .core_x     (core_x),
        .core_y     (core_y),
        .core_win   (core_win),
        .core_done  (core_done),
        .core_out   (core_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_class  (res_class),
        .res_err    (res_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]       img [PIXELS];
    logic [CLS_W-1:0] model_cls = '0;
    bit               model_done_en = 1'b1;
    logic [4:0]       exp_q [$];

    typedef struct {
        int         sel;
        bit         rnd;
        bit         done_en;
        logic [3:0] cls;
        int         stall;
        logic [3:0] exp_class;
        bit         exp_err;
    } frame_t;

    frame_t frames [4];

    // Core model: reset clears it, START arms it, it infers for 576 cycles
    // from the edge after ARM and raises done one cycle into WAIT.
    int cst = 0;
    int ccnt = 0;
    always @(posedge CLK) begin
        if (core_rst === 1'b1) begin
            cst <= 0;
            ccnt <= 0;
            core_done <= 1'b0;
            core_out <= '0;
        end else begin
            case (cst)
                0: if (core_start === 1'b1) cst <= 1;
                1: cst <= 2;
                2: begin
                    if (ccnt == 576) begin
                        core_done <= model_done_en;
                        core_out  <= model_cls;
                        cst <= 3;
                    end else begin
                        ccnt <= ccnt + 1;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int sel, input int p);
        case (sel)
            0:       return 8'(p % 256);
            1:       return 8'($urandom);
            default: return 8'(p * 37 + 11);
        endcase
    endfunction

    function automatic logic [WIN_W-1:0] exp_win(input int x, input int y);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                w[199 - 40 * r - 8 * c -: 8] = img[(y + r) * 28 + x + c];
        return w;
    endfunction

    task automatic load_frame(input int sel, input bit rnd);
        int acc = 0;
        int cyc = 0;
        bit rdy, v;
        for (int p = 0; p < PIXELS; p++) img[p] = pat(sel, p);
        while (acc < PIXELS && cyc < 20000) begin
            @(negedge CLK);
            rdy = pix_ready;
            v = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            pix_valid = v;
            pix_data = v ? img[acc] : 8'($urandom);
            @(posedge CLK);
            cyc++;
            if (rdy && v) acc++;
        end
        check("load_accepts", acc, PIXELS);
    endtask

    // Starts at the accept edge of pixel 783; negedge k lies in cycle t+k.
    task automatic run_after(input frame_t f);
        int k;
        int bad_xy = 0, bad_win = 0, bad_rdy = 0, bad_hold = 0;
        bit got = 1'b0;
        logic [4:0] e;
        model_cls = f.cls;
        model_done_en = f.done_en;
        exp_q.push_back({f.exp_err, f.exp_class});
        res_ready = (f.stall == 0);
        for (k = 1; k <= 579; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                pix_valid = 1'b1;
                pix_data = 8'hAA;
            end
            if (pix_ready !== 1'b0) bad_rdy++;
            if (k == 1) begin
                check("crst_pulse", core_rst, 1);
                check("crst_no_start", core_start, 0);
            end else if (k == 2) begin
                check("strt_rst_low", core_rst, 0);
                check("strt_pulse", core_start, 1);
            end else if (k == 3) begin
                check("arm_start_low", core_start, 0);
                check("arm_win_zero", core_win, 0);
            end else begin
                int pos, ex, ey;
                pos = k - 4;
                ex = pos % 24;
                ey = pos / 24;
                if (core_x !== 5'(ex) || core_y !== 5'(ey)) bad_xy++;
                if (core_win !== exp_win(ex, ey)) bad_win++;
                if (f.sel == 0 && pos == 0) begin
                    check("win00_top", core_win[199:192], 8'h00);
                    check("win00_bot", core_win[7:0], 8'h74);
                end
                if (f.sel == 0 && pos == 575) check("win2323_bot", core_win[7:0], 8'h0F);
            end
        end
        check("scan_xy_raster", bad_xy, 0);
        check("scan_window", bad_win, 0);
        k = 579;
        while (!got && k < 700) begin
            @(negedge CLK);
            k++;
            if (k == 580) begin
                check("wait_xy_zero", {core_x, core_y}, 0);
                check("wait_win_zero", core_win, 0);
            end
            if (res_valid === 1'b1) got = 1'b1;
            else if (pix_ready !== 1'b0) bad_rdy++;
        end
        if (got && f.stall == 0) pix_valid = 1'b0;
        check("res_latency", k, f.done_en ? 582 : 588);
        e = exp_q.pop_front();
        check("res_class", res_class, e[3:0]);
        check("res_err", res_err, e[4]);
        if (f.stall > 0) begin
            for (int i = 0; i < f.stall; i++) begin
                @(negedge CLK);
                if (res_valid !== 1'b1 || res_class !== e[3:0] || res_err !== e[4] ||
                    pix_ready !== 1'b0) bad_hold++;
            end
            check("res_hold", bad_hold, 0);
        end
        pix_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge CLK);
        check("ignore_pix_outside_load", bad_rdy, 0);
        check("return_load_rdy", pix_ready, 1);
        check("res_valid_clear", res_valid, 0);
        res_ready = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        frames[0] = '{sel: 0, rnd: 1'b0, done_en: 1'b1, cls: 4'd7, stall: 0, exp_class: 4'd7, exp_err: 1'b0};
        frames[1] = '{sel: 1, rnd: 1'b1, done_en: 1'b0, cls: 4'd6, stall: 0, exp_class: 4'd0, exp_err: 1'b1};
        frames[2] = '{sel: 2, rnd: 1'b0, done_en: 1'b1, cls: 4'd9, stall: 20, exp_class: 4'd9, exp_err: 1'b0};
        frames[3] = '{sel: 1, rnd: 1'b1, done_en: 1'b1, cls: 4'd3, stall: 0, exp_class: 4'd3, exp_err: 1'b0};

        repeat (3) @(posedge CLK);
        #1;
        check("rst_pix_ready", pix_ready, 0);
        check("rst_core_rst", core_rst, 1);
        check("rst_core_start", core_start, 0);
        check("rst_xy", {core_x, core_y}, 0);
        check("rst_win", core_win, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_class", res_class, 0);
        check("rst_res_err", res_err, 0);
        @(negedge CLK);
        nRST = 1'b0;
        @(negedge CLK);
        check("post_rst_pix_ready", pix_ready, 1);
        check("post_rst_core_rst", core_rst, 0);

        for (int i = 0; i < 3; i++) begin
            load_frame(frames[i].sel, frames[i].rnd);
            run_after(frames[i]);
        end

        // Reset pulse while the scan sits at (10,3).
        model_cls = 4'd5;
        model_done_en = 1'b1;
        load_frame(2, 1'b0);
        for (int k = 1; k <= 86; k++) @(negedge CLK);
        check("abort_pos", {core_x, core_y}, {5'd10, 5'd3});
        nRST = 1'b1;
        pix_valid = 1'b0;
        @(posedge CLK);
        #1;
        check("abort_core_rst", core_rst, 1);
        check("abort_xy", {core_x, core_y}, 0);
        check("abort_core_start", core_start, 0);
        check("abort_res_valid", res_valid, 0);
        check("abort_pix_ready", pix_ready, 0);
        @(negedge CLK);
        nRST = 1'b0;
        @(negedge CLK);
        check("abort_load_rdy", pix_ready, 1);
        check("abort_core_rst_low", core_rst, 0);

        load_frame(frames[3].sel, frames[3].rnd);
        run_after(frames[3]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
